lfsr_gen: RTL and testbench

Parametrised Fibonacci LFSR pseudo-random generator, the successor to the fixed 26-bit load/shift LFSR. Adds:
- configurable width, tap mask and reset seed;
- multi-bit advance per cycle;
- enable gating and zero-seed rejection;
- on-chip period measurement.
Used as a stimulus/scrambler source by test benches and datapath blocks.

---
 rtl/lfsr_step.sv | 16 +
 rtl/lfsr_gen.sv | 88 ++++++++
 tb/tb_lfsr_gen.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_step.sv
// One Fibonacci LFSR shift: feedback is the XOR of the tapped state bits,
// shifted in at bit 0.
module lfsr_step #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
  input  logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] s_next
);

  logic fb;

  assign fb     = ^(s & TAPS);
  assign s_next = {s[WIDTH-2:0], fb};

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR generator with multi-step advance, zero-seed
// rejection and measurement of the sequence period in enabled cycles.
module lfsr_gen #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
  parameter logic [WIDTH-1:0] SEED     = 8'h01,
  parameter int               STEPS    = 1,
  parameter int               PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [WIDTH-1:0]    din,
  output logic [WIDTH-1:0]    q,
  output logic [STEPS-1:0]    out_bits,
  output logic                wrap,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                load_err
);

  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]    seed_reg;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] cnt_inc;
  logic [WIDTH-1:0]    stage [0:STEPS];
  logic [WIDTH-1:0]    q_adv;

  // STEPS single shifts chained combinationally so one enabled cycle advances
  // the state STEPS times; the later shifts push earlier feedback bits upward.
  assign stage[0] = q;

  for (genvar i = 0; i < STEPS; i++) begin : g_step
    lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_step (
      .s      (stage[i]),
      .s_next (stage[i+1])
    );
  end

  assign q_adv   = stage[STEPS];
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q            <= SEED;
      seed_reg     <= SEED;
      cnt          <= '0;
      period       <= '0;
      out_bits     <= '0;
      wrap         <= 1'b0;
      period_valid <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        // A zero seed would lock the register up, so it is refused outright.
        if (din != '0) begin
          q            <= din;
          seed_reg     <= din;
          cnt          <= '0;
          period_valid <= 1'b0;
          out_bits     <= '0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (en) begin
        q        <= q_adv;
        out_bits <= q_adv[STEPS-1:0];
        if (q_adv == seed_reg) begin
          wrap         <= 1'b1;
          period       <= cnt_inc;
          period_valid <= 1'b1;
          cnt          <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: a table of known vectors, a reference
// model feeding a scoreboard queue, and hand sequences for wrap/reset cases.
module tb_lfsr_gen;

  typedef struct {
    logic [7:0]  q;
    logic        out;
    logic        wrap;
    logic        lerr;
    logic [15:0] period;
    logic        pv;
  } exp_t;

  typedef struct {
    logic       en;
    logic       load;
    logic [7:0] din;
    logic [7:0] q;
    logic       out;
    logic       wrap;
    logic       lerr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, load = 1'b0;
  logic [7:0]  din = '0;
  logic [7:0]  q;
  logic [0:0]  out_bits;
  logic        wrap, period_valid, load_err;
  logic [15:0] period;

  logic        en8 = 1'b0, load8 = 1'b0;
  logic [7:0]  din8 = '0;
  logic [7:0]  q8, ob8;
  logic        wrap8, pv8, lerr8;
  logic [15:0] period8;

  int tests = 0;
  int errors = 0;

  exp_t sb[$];
  vec_t vecs[11];

  logic [7:0]  m_q, m_seed;
  logic [15:0] m_cnt, m_period;
  logic        m_pv, m_out;

  always #5 clk = ~clk;

  lfsr_gen u_dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .din(din),
    .q(q), .out_bits(out_bits), .wrap(wrap), .period(period),
    .period_valid(period_valid), .load_err(load_err)
  );

  lfsr_gen #(.STEPS(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en8), .load(load8), .din(din8),
    .q(q8), .out_bits(ob8), .wrap(wrap8), .period(period8),
    .period_valid(pv8), .load_err(lerr8)
  );

  function automatic logic [7:0] mstep(input logic [7:0] x);
    logic fb;
    fb = x[7] ^ x[5] ^ x[4] ^ x[3];
    return {x[6:0], fb};
  endfunction

  task automatic modelReset();
    m_q = 8'h01; m_seed = 8'h01; m_cnt = '0; m_period = '0;
    m_pv = 1'b0; m_out = 1'b0;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; load = 1'b0; en8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  // Drive one cycle, push the model's prediction, then sample after the edge.
  task automatic applyStimulus(input logic e, input logic l, input logic [7:0] d);
    exp_t x;
    logic [7:0]  nq;
    logic [15:0] inc;
    @(negedge clk);
    en = e; load = l; din = d;
    x.wrap = 1'b0; x.lerr = 1'b0;
    if (l) begin
      if (d != 8'h00) begin
        m_q = d; m_seed = d; m_cnt = '0; m_pv = 1'b0; m_out = 1'b0;
      end else begin
        x.lerr = 1'b1;
      end
    end else if (e) begin
      nq = mstep(m_q);
      m_out = nq[0];
      inc = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
      if (nq == m_seed) begin
        x.wrap = 1'b1; m_period = inc; m_pv = 1'b1; m_cnt = '0;
      end else begin
        m_cnt = inc;
      end
      m_q = nq;
    end
    x.q = m_q; x.out = m_out; x.period = m_period; x.pv = m_pv;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name);
    exp_t x;
    tests++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: scoreboard empty", name);
      return;
    end
    x = sb.pop_front();
    if (q !== x.q || out_bits[0] !== x.out || wrap !== x.wrap || load_err !== x.lerr ||
        period !== x.period || period_valid !== x.pv) begin
      errors++;
      $display("[TB] FAIL %s: got q=%h out=%b wrap=%b lerr=%b period=%0d pv=%b, expected q=%h out=%b wrap=%b lerr=%b period=%0d pv=%b",
               name, q, out_bits[0], wrap, load_err, period, period_valid,
               x.q, x.out, x.wrap, x.lerr, x.period, x.pv);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int wraps;
    int wrap_at;

    vecs[0]  = '{1'b1, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 8'h08, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 8'h23, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 8'h47, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 8'h8E, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 8'h8E, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 8'hB4, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 8'hB4, 1'b0, 1'b0, 1'b0};

    doReset();
    checkVal("reset q", {24'h0, q}, 32'h01);
    checkVal("reset flags", {28'h0, out_bits[0], wrap, period_valid, load_err}, 32'h0);
    checkVal("reset period", {16'h0, period}, 32'h0);
    checkVal("reset q8", {24'h0, q8}, 32'h01);
    checkVal("reset ob8", {24'h0, ob8}, 32'h0);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].en, vecs[i].load, vecs[i].din);
      checkOutput($sformatf("vec%0d model", i));
      checkVal($sformatf("vec%0d q", i), {24'h0, q}, {24'h0, vecs[i].q});
      checkVal($sformatf("vec%0d out", i), {31'h0, out_bits[0]}, {31'h0, vecs[i].out});
      checkVal($sformatf("vec%0d wrap/lerr", i), {30'h0, wrap, load_err},
               {30'h0, vecs[i].wrap, vecs[i].lerr});
    end
    checkVal("load clears pv", {31'h0, period_valid}, 32'h0);

    // Full period from the reset seed: exactly one wrap, on the 255th advance.
    doReset();
    wraps = 0; wrap_at = 0;
    for (int i = 1; i <= 255; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("period run");
      if (wrap) begin wraps++; wrap_at = i; end
    end
    checkVal("wrap count", wraps, 1);
    checkVal("wrap position", wrap_at, 255);
    checkVal("wrap q", {24'h0, q}, 32'h01);
    checkVal("period", {16'h0, period}, 32'd255);
    checkVal("period_valid", {31'h0, period_valid}, 32'h1);

    // Eight shifts per cycle.
    doReset();
    wraps = 0; wrap_at = 0;
    for (int i = 1; i <= 255; i++) begin
      @(negedge clk);
      en8 = 1'b1;
      @(posedge clk);
      #1;
      if (i == 1) begin
        checkVal("steps8 first q", {24'h0, q8}, 32'h1C);
        checkVal("steps8 first out", {24'h0, ob8}, 32'h1C);
      end
      if (wrap8) begin wraps++; wrap_at = i; end
    end
    @(negedge clk);
    en8 = 1'b0;
    checkVal("steps8 wrap count", wraps, 1);
    checkVal("steps8 wrap position", wrap_at, 255);
    checkVal("steps8 q", {24'h0, q8}, 32'h01);
    checkVal("steps8 period", {16'h0, period8}, 32'd255);
    checkVal("steps8 pv", {31'h0, pv8}, 32'h1);

    // Asynchronous reset between edges, then resume.
    doReset();
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("pre-async run");
    end
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkVal("async q", {24'h0, q}, 32'h01);
    checkVal("async pv", {31'h0, period_valid}, 32'h0);
    checkVal("async period", {16'h0, period}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("post-async run");
    end
    checkVal("post-async q", {24'h0, q}, 32'h8E);

    // Alternating enable: only enabled cycles count toward the period.
    doReset();
    for (int i = 0; i < 510; i++) begin
      applyStimulus((i % 2) == 0, 1'b0, 8'h00);
      checkOutput("toggle run");
    end
    checkVal("toggle period", {16'h0, period}, 32'd255);
    checkVal("toggle pv", {31'h0, period_valid}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
